fact_engine: RTL and testbench
==============================

Name: fact_engine

Overview:
- Parametrised iterative factorial engine: accepts an unsigned operand n via a ready/valid input handshake and computes n!, one multiply per clock.
- Presents the result on a ready/valid output handshake, with overflow detection and a selectable saturate/wrap mode.
- Drop-in arithmetic worker for control datapaths that need combinatorial counts; successor to the fixed 32-in/64-out factorial FSM.

Parameters:
- IN_W, 32, operand width; legal range 2 <= IN_W <= OUT_W.
- OUT_W, 64, result and accumulator width.
- SATURATE, 1 — 1: on overflow stop and return all-ones; 0: continue with product truncated to OUT_W bits (modulo 2^OUT_W).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  operand n present.
- in_ready  output  1  engine can accept an operand.
- n  input  IN_W  unsigned operand.
- out_valid  output  1  result and overflow valid.
- out_ready  input  1  consumer accepts result.
- result  output  OUT_W  n! per mode.
- overflow  output  1  true n! exceeded 2^OUT_W-1.
- busy  output  1  high in CALC.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc=0; cnt=0; result=0; overflow=0; out_valid=0; busy=0. in_ready=1 once reset deasserts.
- States: IDLE, CALC, DONE. in_ready = (state==IDLE); busy = (state==CALC); out_valid = (state==DONE). All three decode combinationally from the state register.
- IDLE: on in_valid&&in_ready at edge k: cnt<=n, acc<=1, overflow<=0, go to CALC. Otherwise hold; result and overflow keep their last values.
- CALC, each edge:
  - If cnt<=1: result<=acc; go to DONE.
  - Else: compute p = acc*cnt at full OUT_W+IN_W width.
    - If p[OUT_W+IN_W-1:OUT_W] != 0: overflow<=1.
      - SATURATE=1: result<=all-ones; go to DONE immediately.
      - SATURATE=0: acc<=p[OUT_W-1:0]; cnt<=cnt-1.
    - Else: acc<=p[OUT_W-1:0]; cnt<=cnt-1.
- Latency, no overflow: out_valid rises at edge k+max(n,1). Examples: n=0 and n=1 give latency 1; n=5 gives latency 5.
- Overflow with SATURATE=1: latency < n.
- 0! = 1 and 1! = 1.
- DONE: result and overflow held stable while out_valid=1. On out_valid&&out_ready go to IDLE. A new operand is accepted no earlier than the edge after the result handshake.
- in_valid during CALC or DONE: ignored. The source must hold it, standard ready/valid.
- Sticky overflow: in wrap mode, once set, overflow stays 1 until the next accepted operand.
- cnt never underflows: the cnt<=1 check precedes the decrement, including n=0.
- Reset mid-CALC or mid-DONE: aborts immediately to reset values; no out_valid is produced for the aborted operand.
- Inputs n, in_valid and out_ready may change at any time outside the handshake without effect.

Decomposition:
- Shared package fact_pkg holds:
  - the state enum: IDLE=2'd0, CALC=2'd1, DONE=2'd2; 2'd3 is illegal and decodes to IDLE;
  - the default width constants FACT_IN_W=32 and FACT_OUT_W=64.
- One natural sub-module, fact_mul_ovf: combinational OUT_W x IN_W multiplier producing the truncated product and an overflow flag. Isolates the multiplier for retiming or a later multi-cycle replacement.

Test Plan:
- Reset release, then n=5 at edge k with out_ready=1 -> out_valid at edge k+5, result=120, overflow=0, busy high for 5 cycles; in_ready returns 1 the cycle after the handshake.
- n=0, then n=1, back-to-back -> each result=1, overflow=0, latency 1. n=20 -> result=2432902008176640000 (0x21C3677C82B40000), overflow=0, latency 20.
- SATURATE=1, n=21 -> overflow=1, result=0xFFFF_FFFF_FFFF_FFFF, out_valid earlier than edge k+21. SATURATE=0, n=21 -> overflow=1, result=21! mod 2^64 = 0xC507_7D36_B8C4_0000, latency 21.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> result and overflow stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> IDLE next edge, then the second operand is accepted.
- Reset pulse (rst=0 for 1 cycle) during CALC at n=10 -> outputs return to reset values asynchronously, no out_valid. A following n=3 -> result=6 at latency 3.
- Parameter sweep IN_W=8, OUT_W=16, n=8 -> result=40320, overflow=0; n=9 -> overflow=1, result=0xFFFF (SATURATE=1).

Source files
------------

// File: rtl/fact_pkg.sv
// fact_pkg: shared types and default widths for the factorial engine.
// Holds the FSM state encoding and the default operand/result widths.
package fact_pkg;

    localparam int FACT_IN_W  = 32;
    localparam int FACT_OUT_W = 64;

    // 2'd3 is unused and treated as IDLE by the engine.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fact_mul_ovf.sv
// fact_mul_ovf: combinational OUT_W x IN_W multiply with overflow flag.
// Ports: a (OUT_W), b (IN_W) in; prod (low OUT_W bits), ovf (high part nonzero) out.
module fact_mul_ovf
    import fact_pkg::*;
#(
    parameter int IN_W  = FACT_IN_W,
    parameter int OUT_W = FACT_OUT_W
) (
    input  logic [OUT_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] prod,
    output logic             ovf
);

    logic [OUT_W+IN_W-1:0] full;

    // Both operands are zero-extended so the product is computed at full width.
    assign full = {{IN_W{1'b0}}, a} * {{OUT_W{1'b0}}, b};
    assign prod = full[OUT_W-1:0];
    assign ovf  = |full[OUT_W+IN_W-1:OUT_W];

endmodule

// File: rtl/fact_engine.sv
// fact_engine: iterative n! engine, one multiply per clock, ready/valid in and out.
// Ports: clk, rst (async active-low), in_valid/in_ready/n, out_valid/out_ready/result/overflow, busy.
module fact_engine
    import fact_pkg::*;
#(
    parameter int IN_W     = FACT_IN_W,
    parameter int OUT_W    = FACT_OUT_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IN_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;

    logic [OUT_W-1:0] prod;
    logic             mul_ovf;
    logic             cnt_le1;

    fact_mul_ovf #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_mul (
        .a    (acc_q),
        .b    (cnt_q),
        .prod (prod),
        .ovf  (mul_ovf)
    );

    // The cnt<=1 test precedes any decrement, so n=0 never wraps cnt.
    assign cnt_le1 = (cnt_q[IN_W-1:1] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        case (state_q)
            CALC: begin
                if (cnt_le1) begin
                    res_d   = acc_q;
                    state_d = DONE;
                end else if (mul_ovf) begin
                    ovf_d = 1'b1;
                    if (SATURATE) begin
                        res_d   = '1;
                        state_d = DONE;
                    end else begin
                        acc_d = prod;
                        cnt_d = cnt_q - IN_W'(1);
                    end
                end else begin
                    acc_d = prod;
                    cnt_d = cnt_q - IN_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            // IDLE and the unused encoding behave identically.
            default: begin
                if (in_valid) begin
                    cnt_d   = n;
                    acc_d   = OUT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = CALC;
                end
            end
        endcase
    end

    assign busy      = (state_q == CALC);
    assign out_valid = (state_q == DONE);
    assign in_ready  = !(busy || out_valid);
    assign result    = res_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: scoreboard bench for fact_engine (saturate, wrap and 8/16-bit builds).
// Drivers push expected results on acceptance; per-instance monitors pop and compare.
module tb_fact_engine;

    typedef struct {
        logic [63:0] res;
        logic        ovf;
        int          acc;
        int          lat;
        bit          exact;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   nchk = 0;
    int   nerr = 0;

    logic        a_iv = 0, a_ir, a_ov, a_or = 1, a_ovf, a_bz;
    logic [31:0] a_n = 0;
    logic [63:0] a_res;
    logic        b_iv = 0, b_ir, b_ov, b_or = 1, b_ovf, b_bz;
    logic [31:0] b_n = 0;
    logic [63:0] b_res;
    logic        c_iv = 0, c_ir, c_ov, c_or = 1, c_ovf, c_bz;
    logic [7:0]  c_n = 0;
    logic [15:0] c_res;

    exp_t qa[$], qb[$], qc[$];
    bit   a_seen = 0, b_seen = 0, c_seen = 0;
    int   a_vc = 0, b_vc = 0, c_vc = 0;
    int   a_bcnt = 0;

    fact_engine #(.IN_W(32), .OUT_W(64), .SATURATE(1'b1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .n(a_n),
        .out_valid(a_ov), .out_ready(a_or), .result(a_res),
        .overflow(a_ovf), .busy(a_bz)
    );

    fact_engine #(.IN_W(32), .OUT_W(64), .SATURATE(1'b0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .n(b_n),
        .out_valid(b_ov), .out_ready(b_or), .result(b_res),
        .overflow(b_ovf), .busy(b_bz)
    );

    fact_engine #(.IN_W(8), .OUT_W(16), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .n(c_n),
        .out_valid(c_ov), .out_ready(c_or), .result(c_res),
        .overflow(c_ovf), .busy(c_bz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_lat(input string nm, input int lat, input exp_t e);
        if (e.exact) chk(nm, 64'(lat), 64'(e.lat));
        else chk({nm, "_early"}, {63'd0, lat < e.lat}, 64'd1);
    endtask

    always @(negedge clk) begin
        if (a_bz) a_bcnt++;
        if (rst && a_ov) begin
            if (qa.size() == 0) chk("a_spurious_valid", {63'd0, a_ov}, 64'd0);
            else begin
                if (!a_seen) begin a_seen = 1; a_vc = cyc; end
                chk("a_result", a_res, qa[0].res);
                chk("a_overflow", {63'd0, a_ovf}, {63'd0, qa[0].ovf});
                if (a_or) begin
                    chk_lat("a_latency", a_vc - qa[0].acc, qa[0]);
                    void'(qa.pop_front());
                    a_seen = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_ov) begin
            if (qb.size() == 0) chk("b_spurious_valid", {63'd0, b_ov}, 64'd0);
            else begin
                if (!b_seen) begin b_seen = 1; b_vc = cyc; end
                chk("b_result", b_res, qb[0].res);
                chk("b_overflow", {63'd0, b_ovf}, {63'd0, qb[0].ovf});
                if (b_or) begin
                    chk_lat("b_latency", b_vc - qb[0].acc, qb[0]);
                    void'(qb.pop_front());
                    b_seen = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && c_ov) begin
            if (qc.size() == 0) chk("c_spurious_valid", {63'd0, c_ov}, 64'd0);
            else begin
                if (!c_seen) begin c_seen = 1; c_vc = cyc; end
                chk("c_result", {48'd0, c_res}, qc[0].res);
                chk("c_overflow", {63'd0, c_ovf}, {63'd0, qc[0].ovf});
                if (c_or) begin
                    chk_lat("c_latency", c_vc - qc[0].acc, qc[0]);
                    void'(qc.pop_front());
                    c_seen = 0;
                end
            end
        end
    end

    function automatic bit rdy(input int sel);
        case (sel)
            0: return a_ir;
            1: return b_ir;
            default: return c_ir;
        endcase
    endfunction

    function automatic int qsize(input int sel);
        case (sel)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    // Called at posedge+#1; acceptance happens on the following edge.
    task automatic send(input int sel, input logic [31:0] v, input logic [63:0] r,
                        input bit o, input int lat, input bit exact, input bit push);
        exp_t e;
        int t;
        e = '{res: r, ovf: o, acc: 0, lat: lat, exact: exact};
        case (sel)
            0: begin a_iv = 1; a_n = v; end
            1: begin b_iv = 1; b_n = v; end
            default: begin c_iv = 1; c_n = v[7:0]; end
        endcase
        t = 0;
        while (!rdy(sel) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rdy(sel)) chk("accept_timeout", 64'(t), 64'd0);
        else begin
            e.acc = cyc + 1;
            if (push) begin
                case (sel)
                    0: qa.push_back(e);
                    1: qb.push_back(e);
                    default: qc.push_back(e);
                endcase
            end
        end
        @(posedge clk); #1;
        a_iv = 0; b_iv = 0; c_iv = 0;
    endtask

    task automatic wait_idle(input int sel);
        int t;
        t = 0;
        while (qsize(sel) != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (qsize(sel) != 0) chk("drain_timeout", 64'(qsize(sel)), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", a_res, 64'd0);
        chk("rst_overflow", {63'd0, a_ovf}, 64'd0);
        chk("rst_out_valid", {63'd0, a_ov}, 64'd0);
        chk("rst_busy", {63'd0, a_bz}, 64'd0);
        chk("rst_c_result", {48'd0, c_res}, 64'd0);
        rst = 1;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'd0, a_ir}, 64'd1);

        b0 = a_bcnt;
        send(0, 5, 64'd120, 0, 5, 1, 1);
        wait_idle(0);
        chk("busy_cycles_n5", 64'(a_bcnt - b0), 64'd5);
        chk("in_ready_after_hs", {63'd0, a_ir}, 64'd1);

        send(0, 0, 64'd1, 0, 1, 1, 1);
        send(0, 1, 64'd1, 0, 1, 1, 1);
        send(0, 20, 64'h21C3677C82B40000, 0, 20, 1, 1);
        send(0, 21, 64'hFFFFFFFFFFFFFFFF, 1, 21, 0, 1);
        wait_idle(0);

        send(1, 21, 64'hC5077D36B8C40000, 1, 21, 1, 1);
        send(1, 6, 64'd720, 0, 6, 1, 1);
        wait_idle(1);

        send(2, 8, 64'd40320, 0, 8, 1, 1);
        send(2, 9, 64'hFFFF, 1, 9, 0, 1);
        send(2, 2, 64'd2, 0, 2, 1, 1);
        wait_idle(2);

        a_or = 0;
        send(0, 3, 64'd6, 0, 3, 1, 1);
        t = 0;
        while (!a_ov && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_out_valid", {63'd0, a_ov}, 64'd1);
        a_iv = 1;
        a_n = 4;
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_in_ready", {63'd0, a_ir}, 64'd0);
            chk("bp_busy", {63'd0, a_bz}, 64'd0);
        end
        a_or = 1;
        send(0, 4, 64'd24, 0, 4, 1, 1);
        wait_idle(0);

        send(0, 10, 64'd0, 0, 10, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_calc_busy", {63'd0, a_bz}, 64'd1);
        rst = 0;
        #1;
        chk("abort_busy", {63'd0, a_bz}, 64'd0);
        chk("abort_out_valid", {63'd0, a_ov}, 64'd0);
        chk("abort_result", a_res, 64'd0);
        chk("abort_overflow", {63'd0, a_ovf}, 64'd0);
        @(posedge clk); #1;
        rst = 1;
        qa.delete();
        a_seen = 0;
        repeat (12) @(posedge clk);
        #1;
        send(0, 3, 64'd6, 0, 3, 1, 1);
        wait_idle(0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
